// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

  typedef enum logic {
    FETCH,
    HALTED
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instruction;
  } fetch_entry_t;

  localparam logic [31:0] PC_INCREMENT   = 32'd4;
  localparam logic [31:0] PC_READ_OFFSET = 32'd8;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetched {pc, instruction} entries; push/pop are pre-qualified by the parent.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  fetch_entry_t     push_entry,
  output fetch_entry_t     head,
  output logic [PTR_W:0]   count,
  output logic             full,
  output logic             empty
);

  fetch_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;

  // Pointers and count are control state; storage carries no reset.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) r_mem[r_wr_ptr] <= push_entry;
  end

  assign head  = r_mem[r_rd_ptr];
  assign count = r_count;
  assign full  = (r_count == (PTR_W+1)'(DEPTH));
  assign empty = (r_count == '0);

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch front end: program counter, halt/fetch FSM and the decode-facing instruction buffer.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD    = 32'hEF00_0000,
  localparam int unsigned CNT_W       = $clog2(FIFO_DEPTH) + 1
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] imem_address,
  input  logic [31:0] imem_read_data,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        decode_ready,
  output logic        instruction_valid,
  output logic [31:0] instruction,
  output logic [31:0] instruction_pc,
  output logic [31:0] register_15,
  output logic        halted
);

  fetch_state_t r_state;
  logic [31:0]  r_fetch_pc;

  fetch_entry_t     w_head;
  fetch_entry_t     w_push_entry;
  logic [CNT_W-1:0] w_count;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic [31:0]      w_branch_pc;

  assign w_branch_pc  = branch_target & ~32'h3;
  assign w_push_entry = '{pc: r_fetch_pc, instruction: imem_read_data};

  // A redirect suppresses both sides of the handshake in its cycle.
  assign w_pop  = instruction_valid && decode_ready && !branch_taken;
  assign w_push = (r_state == FETCH) && !branch_taken && (!w_full || w_pop);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_fetch_pc <= RESET_VECTOR;
      r_state    <= FETCH;
    end else if (branch_taken) begin
      r_fetch_pc <= w_branch_pc;
      r_state    <= FETCH;
    end else if (w_push) begin
      r_fetch_pc <= r_fetch_pc + PC_INCREMENT;
      if (imem_read_data == HALT_WORD) r_state <= HALTED;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push       (w_push),
    .pop        (w_pop),
    .flush      (branch_taken),
    .push_entry (w_push_entry),
    .head       (w_head),
    .count      (w_count),
    .full       (w_full),
    .empty      (w_empty)
  );

  // Head fields are forced to zero whenever the buffer is empty.
  assign imem_address      = r_fetch_pc;
  assign instruction_valid = (w_count != '0);
  assign instruction       = w_empty ? 32'h0 : w_head.instruction;
  assign instruction_pc    = w_empty ? 32'h0 : w_head.pc;
  assign register_15       = w_empty ? 32'h0 : w_head.pc + PC_READ_OFFSET;
  assign halted            = (r_state == HALTED);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: directed phases push expected deliveries, a monitor checks pops.
module tb_instruction_fetch_unit;

  localparam logic [31:0] HALT_WORD = 32'hEF00_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;

  logic        clock;
  logic        reset;
  logic [31:0] imem_address;
  logic [31:0] imem_read_data;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        decode_ready;
  logic        instruction_valid;
  logic [31:0] instruction;
  logic [31:0] instruction_pc;
  logic [31:0] register_15;
  logic        halted;

  logic        halt_en;
  logic [31:0] halt_addr;
  logic        mon_en;
  int          n_checks;
  int          n_pass;
  exp_t        exp_q[$];

  instruction_fetch_unit #(
    .FIFO_DEPTH   (4),
    .RESET_VECTOR (32'h0000_0000),
    .HALT_WORD    (HALT_WORD)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .imem_address      (imem_address),
    .imem_read_data    (imem_read_data),
    .branch_taken      (branch_taken),
    .branch_target     (branch_target),
    .decode_ready      (decode_ready),
    .instruction_valid (instruction_valid),
    .instruction       (instruction),
    .instruction_pc    (instruction_pc),
    .register_15       (register_15),
    .halted            (halted)
  );

  // Memory model: each word holds its own address, except an optional halt word.
  assign imem_read_data = (halt_en && imem_address == halt_addr) ? HALT_WORD : imem_address;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, req);
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic expect_entry(input logic [31:0] pc, input logic [31:0] ins);
    exp_q.push_back('{pc: pc, ins: ins});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"},  {31'h0, instruction_valid}, 32'h0);
    check({tag, "_instr"},  instruction,                32'h0);
    check({tag, "_pc"},     instruction_pc,             32'h0);
    check({tag, "_r15"},    register_15,                32'h0);
    check({tag, "_halted"}, {31'h0, halted},            32'h0);
    check({tag, "_imem"},   imem_address,               32'h0);
  endtask

  // Monitor: every accepted head entry must match the next scoreboard entry.
  always @(negedge clock) begin
    if (mon_en && !reset && instruction_valid && decode_ready && !branch_taken) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_pop: got pc %h, required no delivery", instruction_pc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("deliver_pc",    instruction_pc, e.pc);
        check("deliver_instr", instruction,    e.ins);
        check("deliver_r15",   register_15,    e.pc + 32'd8);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_pass = 0;
    mon_en = 1'b0;
    reset = 1'b1;
    branch_taken = 1'b0;
    branch_target = 32'h0;
    decode_ready = 1'b0;
    halt_en = 1'b0;
    halt_addr = 32'h8;

    // Reset state, then fill with decode stalled.
    step(2);
    mon_en = 1'b1;
    check_reset_outputs("rst0");
    reset = 1'b0;
    check("valid_before_first_edge", {31'h0, instruction_valid}, 32'h0);
    step(1);
    check("valid_after_first_edge", {31'h0, instruction_valid}, 32'h1);
    check("first_pc", instruction_pc, 32'h0);
    step(9);
    check("stall_imem_hold", imem_address, 32'h10);
    check("stall_valid", {31'h0, instruction_valid}, 32'h1);

    // Release decode: stream continues in order from the full buffer.
    expect_entry(32'h0, 32'h0);
    expect_entry(32'h4, 32'h4);
    expect_entry(32'h8, 32'h8);
    decode_ready = 1'b1;
    step(3);

    // Redirect with a full buffer and decode ready at the same edge.
    expect_entry(32'h40, 32'h40);
    branch_taken = 1'b1;
    branch_target = 32'h42;
    step(1);
    branch_taken = 1'b0;
    check("redirect_bubble_valid", {31'h0, instruction_valid}, 32'h0);
    step(1);
    check("redirect_target_valid", {31'h0, instruction_valid}, 32'h1);
    check("redirect_target_pc", instruction_pc, 32'h40);
    step(1);

    // Halt word at 0x8 after restarting from 0.
    halt_en = 1'b1;
    expect_entry(32'h0, 32'h0);
    expect_entry(32'h4, 32'h4);
    expect_entry(32'h8, HALT_WORD);
    branch_taken = 1'b1;
    branch_target = 32'h0;
    step(1);
    branch_taken = 1'b0;
    step(5);
    check("halted_set", {31'h0, halted}, 32'h1);
    check("halted_drained", {31'h0, instruction_valid}, 32'h0);
    check("halted_imem_hold", imem_address, 32'hC);

    // Leaving HALTED by redirect, then refill with decode stalled.
    halt_en = 1'b0;
    decode_ready = 1'b0;
    branch_taken = 1'b1;
    branch_target = 32'h0;
    step(1);
    branch_taken = 1'b0;
    check("unhalt_halted", {31'h0, halted}, 32'h0);
    check("unhalt_imem", imem_address, 32'h0);
    step(4);
    check("refill_valid", {31'h0, instruction_valid}, 32'h1);
    check("refill_imem", imem_address, 32'h10);

    // Reset beats a pending branch with the buffer full.
    reset = 1'b1;
    branch_taken = 1'b1;
    branch_target = 32'h80;
    decode_ready = 1'b1;
    step(1);
    reset = 1'b0;
    branch_taken = 1'b0;
    decode_ready = 1'b0;
    check_reset_outputs("rst1");

    // Address wrap through the top of the address space.
    expect_entry(32'hFFFF_FFF8, 32'hFFFF_FFF8);
    expect_entry(32'hFFFF_FFFC, 32'hFFFF_FFFC);
    expect_entry(32'h0000_0000, 32'h0000_0000);
    branch_taken = 1'b1;
    branch_target = 32'hFFFF_FFF8;
    step(1);
    branch_taken = 1'b0;
    decode_ready = 1'b1;
    step(4);
    decode_ready = 1'b0;
    step(2);
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Front end of the core: owns the program counter, drives the address port of `instruction_memory`, and buffers fetched words in a small FIFO. Decode drains the FIFO through a valid/ready handshake. The unit supplies the head entry's PC+8 as `register_15` for `register_file`. Branch redirects flush the buffer, and a halt word parks the fetcher.

## Interface
- `FIFO_DEPTH`, default 4: buffer entries; a power of two, at least 2.
- `RESET_VECTOR`, default 32'h0000_0000: fetch PC after reset; word aligned.
- `HALT_WORD`, default 32'hEF00_0000: instruction encoding that stops fetching.
- `clock` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `imem_address` out 32: equals `fetch_pc`; goes to `instruction_memory.address`.
- `imem_read_data` in 32: combinational read data from `instruction_memory`.
- `branch_taken` in 1: redirect request, sampled at the rising edge.
- `branch_target` in 32: redirect address; bits [1:0] are ignored.
- `decode_ready` in 1: decode accepts the head entry this cycle.
- `instruction_valid` out 1: FIFO not empty.
- `instruction` out 32: head entry word; 0 when empty.
- `instruction_pc` out 32: head entry PC; 0 when empty.
- `register_15` out 32: `instruction_pc` + 8 (mod 2^32) when valid; 0 when empty.
- `halted` out 1: fetcher is in the HALTED state.

## Operation
- The FSM has two states, FETCH and HALTED. Reset puts it in FETCH.
- Pop occurs when `instruction_valid` && `decode_ready` && !`branch_taken`.
- Push occurs when state==FETCH && !`branch_taken` && (count < FIFO_DEPTH || pop).
  - Push writes {`fetch_pc`, `imem_read_data`} at the tail.
  - On a push, `fetch_pc` advances by 4, mod 2^32, so 32'hFFFF_FFFC wraps to 0.
- If the pushed word equals HALT_WORD, the FSM goes to HALTED.
  - The halt word itself is enqueued and delivered to decode.
  - `fetch_pc` still advances past it.
- In HALTED there are no pushes and `fetch_pc` holds. Pops continue until the FIFO is empty.
- `branch_taken` has priority over every other event in the same cycle:
  - count, read pointer and write pointer all go to 0;
  - no push and no pop occur;
  - `fetch_pc` <= {`branch_target`[31:2], 2'b00};
  - the FSM goes to FETCH (this also leaves HALTED).
- Full FIFO with a simultaneous pop: the push proceeds and count is unchanged.
- Empty FIFO: no pop occurs, regardless of `decode_ready`.
- `reset` overrides everything, including mid-operation and during `branch_taken`:
  - `fetch_pc` = RESET_VECTOR, count = 0, pointers = 0, state = FETCH;
  - outputs go to `instruction_valid`=0, `instruction`=0, `instruction_pc`=0, `register_15`=0, `halted`=0, `imem_address`=RESET_VECTOR.
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally. Count is log2(FIFO_DEPTH)+1 bits.

## Timing
- `imem_address` is combinational from the `fetch_pc` register. The memory read is combinational too, so a fetch completes in the same cycle.
- Fetch-to-decode latency is 1 cycle: a word fetched in cycle N is at the head in cycle N+1.
- After reset is released, the first edge with `reset`=0 pushes RESET_VECTOR. `instruction_valid` is high from the following cycle.
- Redirect penalty is exactly 1 cycle:
  - the edge with `branch_taken` flushes the FIFO;
  - `instruction_valid`=0 in the next cycle;
  - the target entry is valid in the cycle after that.
- Throughput is one instruction per cycle in steady state with `decode_ready`=1. Occupancy then sits at 1.
- All outputs except `imem_address` are functions of registered state only. There is no input-to-output combinational path.

## Structure
- Package `fetch_pkg`:
  - `fetch_state_t` enum {FETCH, HALTED};
  - `fetch_entry_t` struct {pc[31:0], instruction[31:0]};
  - constants PC_INCREMENT = 4 and PC_READ_OFFSET = 8.
- Sub-module `fetch_fifo`: synchronous FIFO of `fetch_entry_t`.
  - Inputs: `push`, `pop`, `flush`.
  - Outputs: `head`, `count`, `full`, `empty`.
  - The parent computes the push/pop qualification; `fetch_fifo` does no gating of its own.
- The parent module holds `fetch_pc`, the FSM and the output muxing.

## Test plan
- Reset, then run free with memory word = address and `decode_ready`=1 → `instruction_pc` sequence 0, 4, 8, …, `register_15` = pc+8, `instruction_valid` high from the 2nd cycle after reset release.
- Hold `decode_ready`=0 for 10 cycles → count reaches 4, then `fetch_pc` holds at 0x10. Release → entries 0x0, 0x4, 0x8, 0xC, 0x10 delivered in order with no loss or duplicate.
- Full FIFO, then assert `branch_taken` (target 0x42) and `decode_ready` at the same edge → FIFO flushed, no pop counted, `instruction_valid`=0 for 1 cycle, next `instruction_pc`=0x40.
- HALT_WORD at 0x8 → entries 0, 4, 8 delivered, `halted`=1, `imem_address` holds 0xC. Then `branch_taken` with target 0x0 → `halted`=0 and fetching restarts at 0.
- Assert `reset` for one cycle with the FIFO full and a branch pending → next cycle all outputs at their reset values, `imem_address`=RESET_VECTOR, no entry survives.
- Branch to 0xFFFF_FFF8 → entries 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0 delivered; `register_15` for 0xFFFF_FFFC equals 0x4.
